// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, 1-cycle-latency imem reads, 2-entry output buffer, redirect flush.
// Optional build macro FETCH_PERF_CNT_EN enables the accepted-fetch counter on fetch_cnt_o.
module fetch_stage #(
  parameter int                 AWIDTH   = 32,
  parameter int                 DWIDTH   = 32,
  parameter logic [AWIDTH-1:0]  BASEADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] imem_addr_o,
  output logic              imem_rd_o,
  input  logic [DWIDTH-1:0] imem_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [31:0]       fetch_cnt_o
);

  logic [AWIDTH-1:0] r_pc;
  logic [AWIDTH-1:0] r_issued_pc;
  logic              r_inflight;
  logic [1:0]        r_cnt;
  logic              r_head;
  logic              r_tail;
  logic [AWIDTH-1:0] r_pc_buf   [2];
  logic [DWIDTH-1:0] r_insn_buf [2];

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [2:0]        w_pending;
  logic [AWIDTH-1:0] w_redirect_pc;

  assign w_pop         = valid_o && ready_i;
  // Buffered entries plus the read still in flight, after this cycle's pop.
  assign w_pending     = {1'b0, r_cnt} + 3'(r_inflight) - 3'(w_pop);
  assign w_issue       = !rst && !redirect_i && (w_pending < 3'd2);
  // A response due in the redirect cycle is dropped here; no read issues in that
  // cycle, so nothing older than the redirect can arrive afterwards.
  assign w_push        = r_inflight && !redirect_i;
  assign w_redirect_pc = redirect_pc_i & ~AWIDTH'(3);

  assign imem_rd_o   = w_issue;
  assign imem_addr_o = r_pc;
  assign valid_o     = (r_cnt != 2'd0);
  assign pc_o        = r_pc_buf[r_head];
  assign insn_o      = r_insn_buf[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= BASEADDR;
      r_issued_pc <= BASEADDR;
      r_inflight  <= 1'b0;
      r_cnt       <= 2'd0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      // NOTE: the buffer storage is reset only because pc_o/insn_o must read 0 after
      // reset; plain data storage normally needs no reset.
      for (int i = 0; i < 2; i++) begin
        r_pc_buf[i]   <= '0;
        r_insn_buf[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch reads the
      // pre-edge values regardless of statement order.
      r_inflight <= w_issue;
      if (w_issue) begin
        r_issued_pc <= r_pc;
      end
      if (redirect_i) begin
        r_pc   <= w_redirect_pc;
        r_cnt  <= 2'd0;
        r_head <= 1'b0;
        r_tail <= 1'b0;
      end else begin
        if (w_issue) begin
          r_pc <= r_pc + AWIDTH'(4);
        end
        if (w_push) begin
          r_pc_buf[r_tail]   <= r_issued_pc;
          r_insn_buf[r_tail] <= imem_data_i;
          r_tail             <= ~r_tail;
        end
        if (w_pop) begin
          r_head <= ~r_head;
        end
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + 2'd1;
          2'b01:   r_cnt <= r_cnt - 2'd1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
    end else if (w_pop) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
`else
  assign fetch_cnt_o = '0;
`endif

endmodule
